zap_fifo_unpacker: RTL and testbench

Read-side companion to the synchronous FIFO. It pops wide words from the FIFO's first-word-fall-through read port, splits each word into narrower slices, and presents them one per cycle on a registered valid/stall stream to the downstream pipeline. Sustained throughput is one slice per cycle across word boundaries, with no bubbles.

---
 rtl/zap_fifo_unpacker_pkg.sv | 23 ++
 rtl/zap_fifo_unpacker_if.sv | 23 ++
 rtl/zap_fifo_unpacker_slice_sel.sv | 26 ++
 rtl/zap_fifo_unpacker.sv | 119 +++++++++++
 tb/tb_zap_fifo_unpacker.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zap_fifo_unpacker_pkg.sv
// Shared types and elaboration helpers for the FIFO unpacker and its sibling packer blocks.
package zap_fifo_unpack_pkg;

  // Width of a slice index; bounds the largest supported IN_WIDTH/OUT_WIDTH ratio.
  localparam int unsigned SLICE_IDX_W = 8;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } slice_order_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

  function automatic bit ratio_legal(int unsigned in_w, int unsigned out_w);
    if (in_w == 0 || out_w == 0) return 1'b0;
    if (in_w % out_w != 0)       return 1'b0;
    return (in_w / out_w) <= (1 << SLICE_IDX_W);
  endfunction

endpackage

// File: rtl/zap_fifo_unpacker_if.sv
// FIFO read port plus downstream valid/stall stream; master is the unpacker side.
interface zap_fifo_unpacker_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
);
  logic [IN_WIDTH-1:0]  i_fifo_data;
  logic                 i_fifo_empty;
  logic                 o_fifo_ack;
  logic                 o_valid;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_last;
  logic                 i_stall;

  modport master (
    input  i_fifo_data, i_fifo_empty, i_stall,
    output o_fifo_ack, o_valid, o_data, o_last
  );

  modport slave (
    output i_fifo_data, i_fifo_empty, i_stall,
    input  o_fifo_ack, o_valid, o_data, o_last
  );
endinterface

// File: rtl/zap_fifo_unpacker_slice_sel.sv
// Combinational slice picker: returns logical slice i_idx of i_word in the requested order.
module zap_unpack_slice_sel
  import zap_fifo_unpack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic [IN_WIDTH-1:0]    i_word,
  input  logic [SLICE_IDX_W-1:0] i_idx,
  input  slice_order_e           i_order,
  output logic [OUT_WIDTH-1:0]   o_slice
);
  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;

  logic [SLICE_IDX_W-1:0] w_phys;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    o_slice = '0;
    w_phys  = (i_order == ORDER_MSB_FIRST) ? SLICE_IDX_W'(RATIO - 1) - i_idx : i_idx;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (w_phys == SLICE_IDX_W'(k)) o_slice = i_word[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule

// File: rtl/zap_fifo_unpacker.sv
// Pops wide FIFO words and streams them out one OUT_WIDTH slice per cycle, bubble-free.
// Define ZAP_UNPACK_MSB_FIRST_EN to emit the most-significant slice first.
module zap_fifo_unpacker
  import zap_fifo_unpack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clear,
  output logic                       o_busy,
  zap_fifo_unpacker_if.master        if_bus
);
  localparam int unsigned RATIO = (OUT_WIDTH == 0) ? 0 : IN_WIDTH / OUT_WIDTH;
  localparam int unsigned REM_W = (RATIO < 1) ? 1 : $clog2(RATIO + 1);

`ifdef ZAP_UNPACK_MSB_FIRST_EN
  localparam slice_order_e ORDER = ORDER_MSB_FIRST;
`else
  localparam slice_order_e ORDER = ORDER_LSB_FIRST;
`endif

  if (!ratio_legal(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
    $error("zap_fifo_unpacker: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
  end

  logic [IN_WIDTH-1:0]    r_hold, w_hold_n;
  logic [REM_W-1:0]       r_rem, w_rem_n;
  logic                   r_valid, w_valid_n;
  logic [OUT_WIDTH-1:0]   r_data, w_data_n;
  logic                   r_last, w_last_n;
  logic                   w_advance, w_ack;
  unpack_state_e          w_state;
  logic [SLICE_IDX_W-1:0] w_drain_idx;
  logic [OUT_WIDTH-1:0]   w_head_slice, w_drain_slice;

  // Slices already emitted from r_hold equal RATIO - r_rem, which is the next logical index.
  assign w_drain_idx = SLICE_IDX_W'(RATIO - 32'(r_rem));

  zap_unpack_slice_sel #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_head_sel (
    .i_word  (if_bus.i_fifo_data),
    .i_idx   (SLICE_IDX_W'(0)),
    .i_order (ORDER),
    .o_slice (w_head_slice)
  );

  zap_unpack_slice_sel #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_drain_sel (
    .i_word  (r_hold),
    .i_idx   (w_drain_idx),
    .i_order (ORDER),
    .o_slice (w_drain_slice)
  );

  always_comb begin
    w_hold_n  = r_hold;
    w_rem_n   = r_rem;
    w_valid_n = r_valid;
    w_data_n  = r_data;
    w_last_n  = r_last;
    w_ack     = 1'b0;
    w_advance = ~r_valid | ~if_bus.i_stall;
    w_state   = (r_rem == '0) ? ST_EMPTY : ST_DRAIN;

    if (i_clear) begin
      w_valid_n = 1'b0;
      w_last_n  = 1'b0;
      w_rem_n   = '0;
    end else if (w_advance) begin
      case (w_state)
        ST_DRAIN: begin
          w_data_n  = w_drain_slice;
          w_rem_n   = r_rem - REM_W'(1);
          w_last_n  = (r_rem == REM_W'(1));
          w_valid_n = 1'b1;
        end
        ST_EMPTY: begin
          if (!if_bus.i_fifo_empty) begin
            // Reset gates the strobe so the FIFO never pops while we are held in reset.
            w_ack     = i_reset_n;
            w_hold_n  = if_bus.i_fifo_data;
            w_data_n  = w_head_slice;
            w_rem_n   = REM_W'(RATIO - 1);
            w_last_n  = (RATIO == 1);
            w_valid_n = 1'b1;
          end else begin
            w_valid_n = 1'b0;
            w_last_n  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the hold register is a plain data register, so resetting it is cheap and keeps X out.
      r_hold  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_hold  <= w_hold_n;
      r_rem   <= w_rem_n;
      r_valid <= w_valid_n;
      r_data  <= w_data_n;
      r_last  <= w_last_n;
    end
  end

  assign if_bus.o_fifo_ack = w_ack;
  assign if_bus.o_valid    = r_valid;
  assign if_bus.o_data     = r_data;
  assign if_bus.o_last     = r_last;
  assign o_busy            = r_valid | (r_rem != '0);

endmodule

// File: tb/tb_zap_fifo_unpacker.sv
// Directed bench for zap_fifo_unpacker (32->8); honours ZAP_UNPACK_MSB_FIRST_EN for slice order.
module tb_zap_fifo_unpacker;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic clear   = 1'b0;
  logic busy;

  zap_fifo_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus ();

  zap_fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_clear   (clear),
    .o_busy    (busy),
    .if_bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    bit clr;
    bit ack;
    bit valid;
    int beat;
    bit last;
    bit busy;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo_q [$];
  logic        s_ack, s_valid, s_last, s_busy;
  logic [7:0]  s_data;

  function automatic logic [7:0] slice_of(logic [31:0] w, int beat);
`ifdef ZAP_UNPACK_MSB_FIRST_EN
    return w[(3 - beat)*8 +: 8];
`else
    return w[beat*8 +: 8];
`endif
  endfunction

  // One clock: present FIFO head, sample at negedge, pop on the edge if acked.
  task automatic cycle();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
    @(negedge clk);
    s_ack   = bus.o_fifo_ack;
    s_valid = bus.o_valid;
    s_data  = bus.o_data;
    s_last  = bus.o_last;
    s_busy  = busy;
    @(posedge clk);
    if (s_ack && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got, exp;
    logic [31:0] w = 32'h5A6B_7C8D;
    vec_t v [3];
    fifo_q.push_back(w);
    for (int i = 0; i < 3; i++) begin
      cycle();
      got = {s_ack, s_valid, s_data, s_last, s_busy};
      total++;
      if (got !== 12'h000) begin
        bad++;
        $display("FAIL reset_hold c%0d got=%h exp=000", i, got);
      end
    end
    rst_n = 1'b1;
    v = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 0, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    for (int i = 0; i < 3; i++) begin
      bus.i_stall = v[i].stall;
      clear       = v[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {v[i].ack, v[i].valid, (v[i].valid ? slice_of(w, v[i].beat) : 8'h00), v[i].last, v[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_release c%0d got=%h exp=%h", i, got, exp);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_single();
    logic [11:0] got, exp;
    logic [31:0] w = 32'hAABB_CCDD;
    vec_t v [6];
    v = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1}, '{0, 0, 0, 1, 1, 0, 1},
          '{0, 0, 0, 1, 2, 0, 1}, '{0, 0, 0, 1, 3, 1, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    fifo_q.push_back(w);
    for (int i = 0; i < 6; i++) begin
      bus.i_stall = v[i].stall;
      clear       = v[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {v[i].ack, v[i].valid, (v[i].valid ? slice_of(w, v[i].beat) : 8'h00), v[i].last, v[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single c%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, exp;
    logic [31:0] w [2];
    vec_t v [10];
    w = '{32'h0302_0100, 32'h0706_0504};
    v = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1}, '{0, 0, 0, 1, 1, 0, 1},
          '{0, 0, 0, 1, 2, 0, 1}, '{0, 0, 1, 1, 3, 1, 1}, '{0, 0, 0, 1, 4, 0, 1},
          '{0, 0, 0, 1, 5, 0, 1}, '{0, 0, 0, 1, 6, 0, 1}, '{0, 0, 0, 1, 7, 1, 1},
          '{0, 0, 0, 0, 0, 0, 0}};
    fifo_q.push_back(w[0]);
    fifo_q.push_back(w[1]);
    for (int i = 0; i < 10; i++) begin
      bus.i_stall = v[i].stall;
      clear       = v[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {v[i].ack, v[i].valid, (v[i].valid ? slice_of(w[v[i].beat/4], v[i].beat%4) : 8'h00),
             v[i].last, v[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL back_to_back c%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [11:0] got, exp;
    logic [31:0] w [2];
    vec_t v [14];
    w = '{32'hAABB_CCDD, 32'h1122_3344};
    v = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1}, '{1, 0, 0, 1, 1, 0, 1},
          '{1, 0, 0, 1, 1, 0, 1}, '{1, 0, 0, 1, 1, 0, 1}, '{0, 0, 0, 1, 1, 0, 1},
          '{0, 0, 0, 1, 2, 0, 1}, '{1, 0, 0, 1, 3, 1, 1}, '{0, 0, 1, 1, 3, 1, 1},
          '{0, 0, 0, 1, 4, 0, 1}, '{0, 0, 0, 1, 5, 0, 1}, '{0, 0, 0, 1, 6, 0, 1},
          '{0, 0, 0, 1, 7, 1, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    fifo_q.push_back(w[0]);
    fifo_q.push_back(w[1]);
    for (int i = 0; i < 14; i++) begin
      bus.i_stall = v[i].stall;
      clear       = v[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {v[i].ack, v[i].valid, (v[i].valid ? slice_of(w[v[i].beat/4], v[i].beat%4) : 8'h00),
             v[i].last, v[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL stall c%0d got=%h exp=%h", i, got, exp);
      end
    end
    bus.i_stall = 1'b0;
  endtask

  task automatic test_clear();
    logic [11:0] got, exp;
    logic [31:0] w [2];
    vec_t v [9];
    w = '{32'hAABB_CCDD, 32'h1122_3344};
    v = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1}, '{0, 1, 0, 1, 1, 0, 1},
          '{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 4, 0, 1}, '{0, 0, 0, 1, 5, 0, 1},
          '{0, 0, 0, 1, 6, 0, 1}, '{0, 0, 0, 1, 7, 1, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    fifo_q.push_back(w[0]);
    fifo_q.push_back(w[1]);
    for (int i = 0; i < 9; i++) begin
      bus.i_stall = v[i].stall;
      clear       = v[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {v[i].ack, v[i].valid, (v[i].valid ? slice_of(w[v[i].beat/4], v[i].beat%4) : 8'h00),
             v[i].last, v[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL clear c%0d got=%h exp=%h", i, got, exp);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [11:0] got, exp;
    logic [31:0] w [2];
    vec_t pre [2];
    vec_t post [4];
    w    = '{32'hAABB_CCDD, 32'h1122_3344};
    pre  = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1}};
    post = '{'{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 4, 0, 1},
             '{0, 1, 0, 1, 5, 0, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    fifo_q.push_back(w[0]);
    fifo_q.push_back(w[1]);
    for (int i = 0; i < 2; i++) begin
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {pre[i].ack, pre[i].valid, (pre[i].valid ? slice_of(w[pre[i].beat/4], pre[i].beat%4) : 8'h00),
             pre[i].last, pre[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL async_pre c%0d got=%h exp=%h", i, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = {bus.o_fifo_ack, bus.o_valid, bus.o_data, bus.o_last, busy};
    total++;
    if (got !== 12'h000) begin
      bad++;
      $display("FAIL async_immediate got=%h exp=000", got);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      got = {s_ack, s_valid, s_data, s_last, s_busy};
      total++;
      if (got !== 12'h000) begin
        bad++;
        $display("FAIL async_held c%0d got=%h exp=000", i, got);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear = post[i].clr;
      cycle();
      got = {s_ack, s_valid, (s_valid ? s_data : 8'h00), s_last, s_busy};
      exp = {post[i].ack, post[i].valid,
             (post[i].valid ? slice_of(w[post[i].beat/4], post[i].beat%4) : 8'h00),
             post[i].last, post[i].busy};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL async_restart c%0d got=%h exp=%h", i, got, exp);
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_stall      = 1'b0;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
